axis_matvec_feeder: RTL



---
 rtl/axis_matvec_feeder_pkg.sv | 10 +
 rtl/axis_matvec_feeder.sv | 55 +++++
 2 files changed

// File: rtl/axis_matvec_feeder_pkg.sv
// axis_matvec_feeder_pkg: shared FSM state type and width helpers for the matvec feeder
package axis_matvec_feeder_pkg;
  typedef enum logic {LOAD, RUN} state_t;
  function automatic int w_row(input int c, input int w_k);
    return c * w_k;
  endfunction
  function automatic int w_out(input int r, input int c, input int w_x, input int w_k);
    return r * c * w_k + c * w_x;
  endfunction
endpackage

// File: rtl/axis_matvec_feeder.sv
// axis_matvec_feeder: loads an R x C weight bank row per sk beat, then emits {k, x} per sx beat on m (clk, rstn async low; sk/sx in, m out)
module axis_matvec_feeder
  import axis_matvec_feeder_pkg::*;
#(
  parameter int R = 8,
  parameter int C = 8,
  parameter int W_X = 8,
  parameter int W_K = 8,
  localparam int W_ROW = w_row(C, W_K),
  localparam int W_OUT = w_out(R, C, W_X, W_K)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sk_valid,
  output logic               sk_ready,
  input  logic [W_ROW-1:0]   sk_data,
  input  logic               sx_valid,
  output logic               sx_ready,
  input  logic [C*W_X-1:0]   sx_data,
  input  logic               sx_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [W_OUT-1:0]   m_data
);
  localparam int RCW = R > 1 ? $clog2(R) : 1;
  state_t                  state;
  logic [RCW-1:0]          row_cnt;
  logic [R-1:0][W_ROW-1:0] bank;
  logic                    sk_hs, sx_hs, last_row;
  assign sk_ready = state == LOAD;
  assign sx_ready = state == RUN && (!m_valid || m_ready);
  assign sk_hs    = sk_valid && sk_ready;
  assign sx_hs    = sx_valid && sx_ready;
  assign last_row = row_cnt == RCW'(R - 1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= LOAD;
      row_cnt <= '0;
      bank    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (sk_hs) begin
        bank[row_cnt] <= sk_data;
        row_cnt       <= last_row ? '0 : row_cnt + RCW'(1);
        if (last_row) state <= RUN;
      end
      if (sx_hs) begin
        m_data <= {bank, sx_data};
        if (sx_last) state <= LOAD;
      end
      m_valid <= sx_hs || (m_valid && !m_ready);
    end
  end
endmodule
